// File: rtl/axis_fork_pipe.sv
// -----------------------------------------------------------------------------
// axis_fork_pipe
// Forks one AXI-Stream word of 2*WIDTH bits onto two independent AXI-Stream
// outputs. The low half goes to data1_o and the high half goes to data2_o.
// Each output has its own DEPTH-entry FIFO. Either consumer can stall without
// stalling the other until its own FIFO fills.
//
// Parameters
//   WIDTH  bits per output half (the input is 2*WIDTH bits)
//   DEPTH  entries per output FIFO (a power of two, >= 2)
//
// Ports
//   aclk, areset                  clock; asynchronous active-high reset
//   data_i_tdata/tvalid/tready    input stream {high, low}
//   data1_o_tdata/tvalid/tready   low-half output stream
//   data2_o_tdata/tvalid/tready   high-half output stream
//   stat_words, stat_stalls       optional 32-bit counters (AXIS_FORK_STATS_EN):
//                                 input handshakes, and cycles stalled at the input
//
// Optional feature macro: AXIS_FORK_STATS_EN
// -----------------------------------------------------------------------------
module axis_fork_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic [2*WIDTH-1:0] data_i_tdata,
    input  logic               data_i_tvalid,
    output logic               data_i_tready,
    output logic [WIDTH-1:0]   data1_o_tdata,
    output logic               data1_o_tvalid,
    input  logic               data1_o_tready,
    output logic [WIDTH-1:0]   data2_o_tdata,
    output logic               data2_o_tvalid,
    input  logic               data2_o_tready
`ifdef AXIS_FORK_STATS_EN
    ,
    output logic [31:0]        stat_words,
    output logic [31:0]        stat_stalls
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Input ready is registered from the next-state FIFO counts. This keeps it
    // low during reset and removes any path from the output readies.
    logic                  in_ready_q;
    logic                  push;
    logic [1:0]            out_ready;
    logic [1:0]            out_valid;
    logic [1:0]            full_d;
    logic [1:0][WIDTH-1:0] out_data;

    // A word is pushed into both FIFOs at once, or into neither.
    assign push      = data_i_tvalid && in_ready_q;
    assign out_ready = {data2_o_tready, data1_o_tready};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [WIDTH-1:0] mem_q [DEPTH];
            logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
            logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
            logic [CW-1:0]    count_q, count_d;
            logic [WIDTH-1:0] tdata_q, tdata_d;
            logic [WIDTH-1:0] wdata;
            logic             pop;

            assign wdata = data_i_tdata[gi*WIDTH +: WIDTH];
            assign pop   = (count_q != '0) && out_ready[gi];

            always_comb begin
                rd_ptr_d = rd_ptr_q + PW'(pop);
                wr_ptr_d = wr_ptr_q + PW'(push);
                count_d  = count_q + CW'(push) - CW'(pop);
                tdata_d  = tdata_q;
                // The output register always holds the next head. If the word
                // being written now becomes the head (FIFO empty after this
                // cycle's pop), it bypasses the array.
                if (count_d != '0) begin
                    if (push && (wr_ptr_q == rd_ptr_d)) begin
                        tdata_d = wdata;
                    end else begin
                        tdata_d = mem_q[rd_ptr_d];
                    end
                end
            end

            always_ff @(posedge aclk) begin
                if (push) begin
                    mem_q[wr_ptr_q] <= wdata;
                end
            end

            always_ff @(posedge aclk or posedge areset) begin
                if (areset) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                    tdata_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                    tdata_q  <= tdata_d;
                end
            end

            assign full_d[gi]    = (count_d == CW'(DEPTH));
            assign out_valid[gi] = (count_q != '0);
            assign out_data[gi]  = tdata_q;
        end
    endgenerate

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= !(|full_d);
        end
    end

    assign data_i_tready  = in_ready_q;
    assign data1_o_tdata  = out_data[0];
    assign data1_o_tvalid = out_valid[0];
    assign data2_o_tdata  = out_data[1];
    assign data2_o_tvalid = out_valid[1];

`ifdef AXIS_FORK_STATS_EN
    logic [31:0] stat_words_q, stat_stalls_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            stat_words_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (push) begin
                stat_words_q <= stat_words_q + 32'd1;
            end
            if (data_i_tvalid && !in_ready_q) begin
                stat_stalls_q <= stat_stalls_q + 32'd1;
            end
        end
    end

    assign stat_words  = stat_words_q;
    assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_axis_fork_pipe.sv
// -----------------------------------------------------------------------------
// tb_axis_fork_pipe
// Directed and randomised-handshake checks for axis_fork_pipe (WIDTH=8, DEPTH=2).
// Inputs are driven and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_axis_fork_pipe;
    localparam int W = 8;
    localparam int N = 1000;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [2*W-1:0] data_i_tdata = '0;
    logic          data_i_tvalid = 1'b0;
    logic          data_i_tready;
    logic [W-1:0]  data1_o_tdata;
    logic          data1_o_tvalid;
    logic          data1_o_tready = 1'b0;
    logic [W-1:0]  data2_o_tdata;
    logic          data2_o_tvalid;
    logic          data2_o_tready = 1'b0;
`ifdef AXIS_FORK_STATS_EN
    logic [31:0]   stat_words;
    logic [31:0]   stat_stalls;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int stall_cnt = 0;
    int word_cnt  = 0;
    logic [2*W-1:0] words [N];

    always #5 aclk = ~aclk;

    axis_fork_pipe #(.WIDTH(W), .DEPTH(2)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .data_i_tdata   (data_i_tdata),
        .data_i_tvalid  (data_i_tvalid),
        .data_i_tready  (data_i_tready),
        .data1_o_tdata  (data1_o_tdata),
        .data1_o_tvalid (data1_o_tvalid),
        .data1_o_tready (data1_o_tready),
        .data2_o_tdata  (data2_o_tdata),
        .data2_o_tvalid (data2_o_tvalid),
        .data2_o_tready (data2_o_tready)
`ifdef AXIS_FORK_STATS_EN
        ,
        .stat_words     (stat_words),
        .stat_stalls    (stat_stalls)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_random();
        int gap;
        int cyc;
        logic hs;
        for (int i = 0; i < N; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) step();
            data_i_tdata  = words[i];
            data_i_tvalid = 1'b1;
            cyc = 0;
            hs  = 1'b0;
            while (!hs) begin
                hs = data_i_tready;
                if (!hs) stall_cnt++;
                step();
                cyc++;
                if (!hs && cyc > 1000) begin
                    check("rnd_in_timeout", 32'(i), 32'(N));
                    data_i_tvalid = 1'b0;
                    return;
                end
            end
            word_cnt++;
            $display("xfer %0d: in %h", i, words[i]);
            data_i_tvalid = 1'b0;
        end
    endtask

    task automatic consume_random(input int k);
        int idx = 0;
        int cyc = 0;
        logic r;
        logic v;
        logic [W-1:0] d;
        logic [2*W-1:0] w;
        while (idx < N && cyc < 20000) begin
            r = ($urandom_range(0, 3) != 0);
            if (k == 0) data1_o_tready = r;
            else        data2_o_tready = r;
            v = (k == 0) ? data1_o_tvalid : data2_o_tvalid;
            d = (k == 0) ? data1_o_tdata  : data2_o_tdata;
            step();
            cyc++;
            if (v && r) begin
                w = words[idx];
                if (k == 0) check("rnd_d1", 32'(d), 32'(w[W-1:0]));
                else        check("rnd_d2", 32'(d), 32'(w[2*W-1:W]));
                idx++;
            end
        end
        if (idx < N) check("rnd_out_timeout", 32'(idx), 32'(N));
        if (k == 0) data1_o_tready = 1'b0;
        else        data2_o_tready = 1'b0;
    endtask

    initial begin
        logic [2*W-1:0] w;

        // Reset state
        repeat (3) step();
        check("rst_in_ready", 32'(data_i_tready), 32'd0);
        check("rst_v1", 32'(data1_o_tvalid), 32'd0);
        check("rst_v2", 32'(data2_o_tvalid), 32'd0);
        check("rst_d1", 32'(data1_o_tdata), 32'd0);
        check("rst_d2", 32'(data2_o_tdata), 32'd0);
        areset = 1'b0;
        step();
        check("ready_after_release", 32'(data_i_tready), 32'd1);

        // Single word, both consumers ready
        data1_o_tready = 1'b1;
        data2_o_tready = 1'b1;
        data_i_tdata   = 16'hA55A;
        data_i_tvalid  = 1'b1;
        step();
        data_i_tvalid  = 1'b0;
        $display("xfer single: in a55a");
        check("single_v1", 32'(data1_o_tvalid), 32'd1);
        check("single_d1", 32'(data1_o_tdata), 32'h5A);
        check("single_v2", 32'(data2_o_tvalid), 32'd1);
        check("single_d2", 32'(data2_o_tdata), 32'hA5);
        step();
        check("single_v1_gone", 32'(data1_o_tvalid), 32'd0);
        check("single_v2_gone", 32'(data2_o_tvalid), 32'd0);
        check("single_d1_hold", 32'(data1_o_tdata), 32'h5A);

        // Output 2 stalled, output 1 flowing
        data2_o_tready = 1'b0;
        data_i_tdata   = 16'h0102;
        data_i_tvalid  = 1'b1;
        step();
        $display("xfer stall2: in 0102");
        check("st2_d1_a", 32'(data1_o_tdata), 32'h02);
        check("st2_d2_a", 32'(data2_o_tdata), 32'h01);
        data_i_tdata = 16'h0304;
        step();
        $display("xfer stall2: in 0304");
        data_i_tvalid = 1'b0;
        check("st2_d1_b", 32'(data1_o_tdata), 32'h04);
        check("st2_d2_b", 32'(data2_o_tdata), 32'h01);
        check("st2_full_ready", 32'(data_i_tready), 32'd0);
        step();
        check("st2_v1_empty", 32'(data1_o_tvalid), 32'd0);
        check("st2_v2_held", 32'(data2_o_tvalid), 32'd1);
        check("st2_d2_held", 32'(data2_o_tdata), 32'h01);
        check("st2_still_full", 32'(data_i_tready), 32'd0);
        data2_o_tready = 1'b1;
        step();
        check("st2_d2_next", 32'(data2_o_tdata), 32'h03);
        check("st2_ready_back", 32'(data_i_tready), 32'd1);
        step();
        check("st2_v2_empty", 32'(data2_o_tvalid), 32'd0);

        // Full FIFO with a simultaneous pop: no accept that cycle
        data1_o_tready = 1'b0;
        data2_o_tready = 1'b0;
        data_i_tdata   = 16'h1111;
        data_i_tvalid  = 1'b1;
        step();
        data_i_tdata = 16'h2222;
        step();
        check("full_ready_low", 32'(data_i_tready), 32'd0);
        data_i_tdata   = 16'h3333;
        data1_o_tready = 1'b1;
        data2_o_tready = 1'b1;
        step();
        check("full_pop_no_accept", 32'(data_i_tready), 32'd1);
        check("full_pop_head", 32'(data1_o_tdata), 32'h22);
        data1_o_tready = 1'b0;
        data2_o_tready = 1'b0;
        step();
        $display("xfer full: in 3333");
        data_i_tvalid = 1'b0;
        check("full_accept_next", 32'(data_i_tready), 32'd0);
        data1_o_tready = 1'b1;
        data2_o_tready = 1'b1;
        step();
        check("full_drain_d1", 32'(data1_o_tdata), 32'h33);
        check("full_drain_d2", 32'(data2_o_tdata), 32'h33);
        step();
        check("full_drain_empty", 32'(data1_o_tvalid), 32'd0);

        // Sustained 1 word/cycle with both consumers ready
        for (int i = 0; i < 100; i++) begin
            w = 16'($urandom);
            data_i_tdata  = w;
            data_i_tvalid = 1'b1;
            check("tput_ready", 32'(data_i_tready), 32'd1);
            step();
            $display("xfer tput %0d: in %h", i, w);
            check("tput_d1", {23'd0, data1_o_tvalid, data1_o_tdata}, {24'd1, w[W-1:0]});
            check("tput_d2", {23'd0, data2_o_tvalid, data2_o_tdata}, {24'd1, w[2*W-1:W]});
        end
        data_i_tvalid = 1'b0;
        step();
        check("tput_empty", 32'(data1_o_tvalid | data2_o_tvalid), 32'd0);

        // Reset with two words buffered
        data1_o_tready = 1'b0;
        data2_o_tready = 1'b0;
        data_i_tdata   = 16'h4444;
        data_i_tvalid  = 1'b1;
        step();
        data_i_tdata = 16'h5555;
        step();
        data_i_tvalid = 1'b0;
        check("mid_v1_before", 32'(data1_o_tvalid), 32'd1);
        areset = 1'b1;
        #1;
        check("mid_rst_v1", 32'(data1_o_tvalid), 32'd0);
        check("mid_rst_v2", 32'(data2_o_tvalid), 32'd0);
        check("mid_rst_d1", 32'(data1_o_tdata), 32'd0);
        check("mid_rst_ready", 32'(data_i_tready), 32'd0);
        step();
        areset = 1'b0;
        data1_o_tready = 1'b1;
        data2_o_tready = 1'b1;
        step();
        check("mid_ready_back", 32'(data_i_tready), 32'd1);
        repeat (3) begin
            step();
            check("mid_no_ghost", 32'(data1_o_tvalid | data2_o_tvalid), 32'd0);
        end
        data1_o_tready = 1'b0;
        data2_o_tready = 1'b0;

        // Random delays on all three interfaces
        for (int i = 0; i < N; i++) words[i] = 16'($urandom);
        fork
            drive_random();
            consume_random(0);
            consume_random(1);
        join
        step();
        check("rnd_end_empty", 32'(data1_o_tvalid | data2_o_tvalid), 32'd0);
`ifdef AXIS_FORK_STATS_EN
        check("stat_words", stat_words, 32'(word_cnt));
        check("stat_stalls", stat_stalls, 32'(stall_cnt));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
